tuser_arb_2to1: RTL and testbench
=================================

Name: tuser_arb_2to1

Overview:
- Packet-granular 2:1 round-robin arbiter placed in front of tuser_in_fsm.
- Lets two AXIS ingress sources (data 256, keep 32, tuser 128) share one tuser-extraction datapath.
- A grant is held for a whole packet, from the first beat through the tlast handshake, so beats of different packets never interleave downstream.

Parameters:
- DATA_W, 256, AXIS tdata width
- KEEP_W, 32, AXIS tkeep width (DATA_W/8)
- TUSER_W, 128, AXIS tuser width
- SRC_TAG_LSB, 120, LSB of the 8-bit source tag field in tuser (used only with the optional feature)

Ports:
- tarb_aclk  in  1  clock
- tarb_arst  in  1  reset: one clock; reset is synchronous and active-low
- tarb_s0_valid  in  1  port 0 AXIS tvalid
- tarb_s0_ready  out  1  port 0 AXIS tready
- tarb_s0_data  in  DATA_W  port 0 tdata
- tarb_s0_keep  in  KEEP_W  port 0 tkeep
- tarb_s0_tlast  in  1  port 0 tlast
- tarb_s0_tuser  in  TUSER_W  port 0 tuser
- tarb_s1_valid, tarb_s1_ready, tarb_s1_data, tarb_s1_keep, tarb_s1_tlast, tarb_s1_tuser: same as port 0, for port 1
- tarb_m_valid  out  1  merged AXIS tvalid (to tin_avalid)
- tarb_m_ready  in  1  merged AXIS tready (from tin_aready)
- tarb_m_data  out  DATA_W  merged tdata
- tarb_m_keep  out  KEEP_W  merged tkeep
- tarb_m_tlast  out  1  merged tlast
- tarb_m_tuser  out  TUSER_W  merged tuser
- dbg_state  out  2  current FSM state encoding
- dbg_last  out  1  index of the last-granted port

Behaviour:
- FSM states: IDLE=2'b00, PKT0=2'b01, PKT1=2'b10. Encoding 2'b11 is illegal and recovers to IDLE on the next clock.
- Reset (tarb_arst==0 at a clock edge):
  - state<=IDLE, last<=1 (so port 0 wins the first contention).
  - All outputs follow the IDLE combinational values below.
- IDLE outputs:
  - tarb_m_valid=0, both s*_ready=0.
  - m_data, m_keep, m_tlast and m_tuser are all zero.
- IDLE transitions:
  - Only s0_valid=1: go to PKT0.
  - Only s1_valid=1: go to PKT1.
  - Both valid: grant the port != last.
  - Neither valid: stay in IDLE.
  - Arbitration costs one cycle; no beat is accepted in IDLE.
- PKTn (combinational, zero-latency pass-through from port n):
  - m_valid=sn_valid and sn_ready=m_ready.
  - m_data, keep, tlast and tuser are driven from port n.
  - The non-granted port's ready is 0.
- PKTn exit:
  - On the beat where sn_valid & m_ready & sn_tlast: last<=n, go to IDLE.
  - Result: at least one bubble cycle between consecutive packets.
- Single-beat packet (tlast on the first beat): PKTn lasts exactly one handshake cycle.
- Backpressure:
  - With m_ready=0, the granted port stalls and its data must stay stable (AXIS rule, upheld by the source).
  - The grant does not change while the packet is incomplete, regardless of the other port's valid.
- Granted source drops valid mid-packet: stay in PKTn; m_valid=0 until it resumes.
- Reset mid-packet:
  - Immediate return to IDLE and last<=1.
  - The downstream packet is truncated. The downstream FSM is reset by the same reset, so no tlast is synthesised.
- No registered datapath; only state and last are flops.

Optional Feature:
- Macro: TARB_SRC_TAG_EN
- Defined: in PKTn, tarb_m_tuser[SRC_TAG_LSB+:8] is replaced by the one-hot source tag (8'h01 for port 0, 8'h02 for port 1). All other tuser bits pass through unchanged.
- Undefined: tuser passes through unmodified.

Decomposition:
- Shared package tarb_pkg:
  - State localparams IDLE, PKT0, PKT1.
  - Width defaults 256/32/128.
  - Tag constants 8'h01/8'h02.
- Sub-module tarb_rr_pick (combinational 2-input round-robin pick from valid[1:0] and last) is natural. The FSM and mux stay in the top module.

Test Plan:
- Reset held 5 cycles with s0_valid=1 -> m_valid=0, both readies 0, dbg_state=00, dbg_last=1; after release, PKT0 is entered on the next edge.
- s0 3-beat packet (data 22222, keep 33333, tuser 44444, tlast on beat 3) with m_ready=1 -> 3 output beats with identical fields, m_tlast on beat 3, then 1 IDLE cycle, dbg_last=0.
- Both ports continuously valid, each sending 2-beat packets -> grant order 0,1,0,1; s1_ready stays 0 throughout every port-0 packet.
- Port 1 granted; m_ready toggles 1,0,1,0 during a 4-beat packet -> s1_ready mirrors m_ready, no beat lost or duplicated, and s0 is not granted until after s1's tlast handshake.
- Reset asserted during beat 2 of a port-0 packet -> next cycle dbg_state=00 and m_valid=0; the first post-reset contention goes to port 0.
- TARB_SRC_TAG_EN defined, port 1 tuser=44444 -> m_tuser[127:120]=8'h02 and lower bits equal 44444. Undefined -> m_tuser=44444 exactly.

Source files
------------

// File: rtl/tarb_pkg.sv
// ----------------------------------------------------------------------------
// tarb_pkg
// Shared constants for the tuser_arb_2to1 packet arbiter:
//   - FSM state encodings (IDLE / PKT0 / PKT1; 2'b11 is illegal)
//   - default AXIS widths (tdata 256, tkeep 32, tuser 128)
//   - one-hot source tags stamped into tuser when TARB_SRC_TAG_EN is defined
// ----------------------------------------------------------------------------
package tarb_pkg;

   // FSM encodings, kept as plain 2-bit constants so the debug port shows
   // the raw state value.
   localparam logic [1:0] IDLE = 2'b00;
   localparam logic [1:0] PKT0 = 2'b01;
   localparam logic [1:0] PKT1 = 2'b10;

   // Default AXIS widths.
   localparam int DATA_W_DEF      = 256;
   localparam int KEEP_W_DEF      = 32;
   localparam int TUSER_W_DEF     = 128;
   localparam int SRC_TAG_LSB_DEF = 120;

   // One-hot source tags.
   localparam logic [7:0] TAG_P0 = 8'h01;
   localparam logic [7:0] TAG_P1 = 8'h02;

   // Tag for a given source index.
   function automatic logic [7:0] src_tag(input logic idx);
      return idx ? TAG_P1 : TAG_P0;
   endfunction

endpackage

// File: rtl/tarb_rr_pick.sv
// ----------------------------------------------------------------------------
// tarb_rr_pick
// Combinational 2-input round-robin pick.
// Ports:
//   valid [1:0] in  : request from port 0 (bit 0) and port 1 (bit 1)
//   last        in  : index of the most recently granted port
//   any         out : at least one port is requesting
//   pick        out : index of the winning port (meaningful only when any=1)
// With a single requester that requester wins; with both requesting, the
// port that was not granted last wins.
// ----------------------------------------------------------------------------
module tarb_rr_pick (
   input  logic [1:0] valid,
   input  logic       last,
   output logic       any,
   output logic       pick
);

   assign any  = |valid;
   assign pick = (&valid) ? ~last : valid[1];

endmodule

// File: rtl/tuser_arb_2to1.sv
// ----------------------------------------------------------------------------
// tuser_arb_2to1
// Packet-granular 2:1 round-robin AXIS arbiter sitting in front of the
// tuser extraction FSM. A grant is held from the first beat of a packet
// through its tlast handshake, so packets never interleave downstream.
// Arbitration takes one IDLE cycle, so consecutive packets are separated by
// at least one bubble. The datapath is purely combinational; the only
// flops are the FSM state and the last-granted index.
//
// Optional feature (macro TARB_SRC_TAG_EN): while a packet is granted,
// m_tuser[SRC_TAG_LSB +: 8] carries a one-hot source tag (8'h01 for port 0,
// 8'h02 for port 1); all other tuser bits pass through. Without the macro
// tuser passes through unmodified.
//
// Ports:
//   tarb_aclk            in   clock
//   tarb_arst            in   synchronous active-low reset
//   tarb_s0_*            AXIS slave port 0 (valid/ready/data/keep/tlast/tuser)
//   tarb_s1_*            AXIS slave port 1 (same as port 0)
//   tarb_m_*             merged AXIS master port
//   dbg_state  [1:0] out current FSM state encoding
//   dbg_last         out index of the last-granted port
// ----------------------------------------------------------------------------
module tuser_arb_2to1
   import tarb_pkg::*;
#(
   parameter int DATA_W      = DATA_W_DEF,
   parameter int KEEP_W      = KEEP_W_DEF,
   parameter int TUSER_W     = TUSER_W_DEF,
   parameter int SRC_TAG_LSB = SRC_TAG_LSB_DEF
) (
   input  logic               tarb_aclk,
   input  logic               tarb_arst,

   input  logic               tarb_s0_valid,
   output logic               tarb_s0_ready,
   input  logic [DATA_W-1:0]  tarb_s0_data,
   input  logic [KEEP_W-1:0]  tarb_s0_keep,
   input  logic               tarb_s0_tlast,
   input  logic [TUSER_W-1:0] tarb_s0_tuser,

   input  logic               tarb_s1_valid,
   output logic               tarb_s1_ready,
   input  logic [DATA_W-1:0]  tarb_s1_data,
   input  logic [KEEP_W-1:0]  tarb_s1_keep,
   input  logic               tarb_s1_tlast,
   input  logic [TUSER_W-1:0] tarb_s1_tuser,

   output logic               tarb_m_valid,
   input  logic               tarb_m_ready,
   output logic [DATA_W-1:0]  tarb_m_data,
   output logic [KEEP_W-1:0]  tarb_m_keep,
   output logic               tarb_m_tlast,
   output logic [TUSER_W-1:0] tarb_m_tuser,

   output logic [1:0]         dbg_state,
   output logic               dbg_last
);

`ifdef TARB_SRC_TAG_EN
   localparam logic TAG_EN = 1'b1;
`else
   localparam logic TAG_EN = 1'b0;
`endif

   logic [1:0] state, state_nxt;
   logic       last, last_nxt;
   logic       req_any, req_pick;
   logic       s0_done, s1_done;

   // --------------------------------------------------------------------
   // Round-robin pick, consulted only in IDLE.
   // --------------------------------------------------------------------
   tarb_rr_pick u_pick (
      .valid ({tarb_s1_valid, tarb_s0_valid}),
      .last  (last),
      .any   (req_any),
      .pick  (req_pick)
   );

   // Final beat of the granted packet is accepted downstream.
   assign s0_done = tarb_s0_valid & tarb_m_ready & tarb_s0_tlast;
   assign s1_done = tarb_s1_valid & tarb_m_ready & tarb_s1_tlast;

   // --------------------------------------------------------------------
   // Next-state logic
   // --------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      last_nxt  = last;
      case (state)
         IDLE: begin
            if (req_any) state_nxt = req_pick ? PKT1 : PKT0;
         end
         PKT0: begin
            // Grant stays put until tlast handshakes, whatever port 1 does.
            if (s0_done) begin
               state_nxt = IDLE;
               last_nxt  = 1'b0;
            end
         end
         PKT1: begin
            if (s1_done) begin
               state_nxt = IDLE;
               last_nxt  = 1'b1;
            end
         end
         // 2'b11 is unreachable in normal operation; fall back to IDLE.
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge tarb_aclk) begin
      if (!tarb_arst) begin
         state <= IDLE;
         last  <= 1'b1;   // port 0 wins the first contention after reset
      end else begin
         state <= state_nxt;
         last  <= last_nxt;
      end
   end

   // --------------------------------------------------------------------
   // Output mux: zero-latency pass-through from the granted port. In IDLE
   // (and the illegal state) everything is driven to zero so no beat can be
   // accepted while arbitrating.
   // --------------------------------------------------------------------
   always_comb begin
      tarb_m_valid  = 1'b0;
      tarb_m_data   = '0;
      tarb_m_keep   = '0;
      tarb_m_tlast  = 1'b0;
      tarb_m_tuser  = '0;
      tarb_s0_ready = 1'b0;
      tarb_s1_ready = 1'b0;
      case (state)
         PKT0: begin
            tarb_m_valid  = tarb_s0_valid;
            tarb_s0_ready = tarb_m_ready;
            tarb_m_data   = tarb_s0_data;
            tarb_m_keep   = tarb_s0_keep;
            tarb_m_tlast  = tarb_s0_tlast;
            tarb_m_tuser  = tarb_s0_tuser;
            if (TAG_EN) tarb_m_tuser[SRC_TAG_LSB +: 8] = src_tag(1'b0);
         end
         PKT1: begin
            tarb_m_valid  = tarb_s1_valid;
            tarb_s1_ready = tarb_m_ready;
            tarb_m_data   = tarb_s1_data;
            tarb_m_keep   = tarb_s1_keep;
            tarb_m_tlast  = tarb_s1_tlast;
            tarb_m_tuser  = tarb_s1_tuser;
            if (TAG_EN) tarb_m_tuser[SRC_TAG_LSB +: 8] = src_tag(1'b1);
         end
         default: ;
      endcase
   end

   assign dbg_state = state;
   assign dbg_last  = last;

endmodule

// File: tb/tb_tuser_arb_2to1.sv
// ----------------------------------------------------------------------------
// tb_tuser_arb_2to1
// Scoreboard bench: each port has a source queue of beats, and every beat
// expected downstream is pushed, in predicted grant order, onto exp_q when
// it is queued. A negedge monitor pops exp_q on every merged handshake and
// also checks grant exclusivity / ready mirroring by state.
// ----------------------------------------------------------------------------
module tb_tuser_arb_2to1;
   import tarb_pkg::*;

   typedef struct {
      logic [255:0] data;
      logic [31:0]  keep;
      logic         tlast;
      logic [127:0] tuser;
      logic         src;
   } beat_t;

   logic         clk = 1'b0;
   logic         arst;
   logic         s0_valid, s0_ready, s0_tlast;
   logic [255:0] s0_data;
   logic [31:0]  s0_keep;
   logic [127:0] s0_tuser;
   logic         s1_valid, s1_ready, s1_tlast;
   logic [255:0] s1_data;
   logic [31:0]  s1_keep;
   logic [127:0] s1_tuser;
   logic         m_valid, m_ready, m_tlast;
   logic [255:0] m_data;
   logic [31:0]  m_keep;
   logic [127:0] m_tuser;
   logic [1:0]   dbg_state;
   logic         dbg_last;

   beat_t src0_q[$];
   beat_t src1_q[$];
   beat_t exp_q[$];
   beat_t mon_e;
   logic [127:0] mon_tuser;
   logic hs0 = 1'b0, hs1 = 1'b0;
   int   n_chk = 0, n_pass = 0;

   always #5 clk = ~clk;

   tuser_arb_2to1 dut (
      .tarb_aclk     (clk),
      .tarb_arst     (arst),
      .tarb_s0_valid (s0_valid),
      .tarb_s0_ready (s0_ready),
      .tarb_s0_data  (s0_data),
      .tarb_s0_keep  (s0_keep),
      .tarb_s0_tlast (s0_tlast),
      .tarb_s0_tuser (s0_tuser),
      .tarb_s1_valid (s1_valid),
      .tarb_s1_ready (s1_ready),
      .tarb_s1_data  (s1_data),
      .tarb_s1_keep  (s1_keep),
      .tarb_s1_tlast (s1_tlast),
      .tarb_s1_tuser (s1_tuser),
      .tarb_m_valid  (m_valid),
      .tarb_m_ready  (m_ready),
      .tarb_m_data   (m_data),
      .tarb_m_keep   (m_keep),
      .tarb_m_tlast  (m_tlast),
      .tarb_m_tuser  (m_tuser),
      .dbg_state     (dbg_state),
      .dbg_last      (dbg_last)
   );

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
   endtask

   task automatic push(input logic p, input logic [255:0] d, input logic [31:0] k,
                       input logic t, input logic [127:0] u, input bit to_exp);
      beat_t b;
      b.data = d; b.keep = k; b.tlast = t; b.tuser = u; b.src = p;
      if (p) src1_q.push_back(b); else src0_q.push_back(b);
      if (to_exp) exp_q.push_back(b);
   endtask

   task automatic drain(input string tag, input int max);
      int n = 0;
      while (exp_q.size() > 0 && n < max) begin
         @(posedge clk); #2;
         n++;
      end
      chk(tag, exp_q.size(), 0);
   endtask

   // Handshakes sampled mid-cycle, consumed by the source models after the edge.
   always @(negedge clk) begin
      hs0 = s0_valid & s0_ready;
      hs1 = s1_valid & s1_ready;
   end

   // Source models: present the head of each queue, advance on handshake.
   always @(posedge clk) begin
      #1;
      if (hs0 && src0_q.size() > 0) src0_q.delete(0);
      if (hs1 && src1_q.size() > 0) src1_q.delete(0);
      s0_valid = (src0_q.size() > 0);
      s1_valid = (src1_q.size() > 0);
      if (src0_q.size() > 0) begin
         s0_data = src0_q[0].data; s0_keep = src0_q[0].keep;
         s0_tlast = src0_q[0].tlast; s0_tuser = src0_q[0].tuser;
      end else begin
         s0_data = '0; s0_keep = '0; s0_tlast = 1'b0; s0_tuser = '0;
      end
      if (src1_q.size() > 0) begin
         s1_data = src1_q[0].data; s1_keep = src1_q[0].keep;
         s1_tlast = src1_q[0].tlast; s1_tuser = src1_q[0].tuser;
      end else begin
         s1_data = '0; s1_keep = '0; s1_tlast = 1'b0; s1_tuser = '0;
      end
   end

   // Downstream monitor and per-state invariants.
   always @(negedge clk) begin
      if (m_valid && m_ready) begin
         if (exp_q.size() == 0) chk("unexpected_beat", 1'b1, 1'b0);
         else begin
            mon_e = exp_q.pop_front();
            mon_tuser = mon_e.tuser;
`ifdef TARB_SRC_TAG_EN
            mon_tuser[127:120] = mon_e.src ? 8'h02 : 8'h01;
`endif
            chk("m_data",  m_data,  mon_e.data);
            chk("m_keep",  m_keep,  mon_e.keep);
            chk("m_tlast", m_tlast, mon_e.tlast);
            chk("m_tuser", m_tuser, mon_tuser);
         end
      end
      if (dbg_state == PKT0) begin
         chk("s1_ready_in_pkt0", s1_ready, 1'b0);
         chk("s0_ready_mirror",  s0_ready, m_ready);
         chk("m_valid_mirror0",  m_valid,  s0_valid);
      end
      if (dbg_state == PKT1) begin
         chk("s0_ready_in_pkt1", s0_ready, 1'b0);
         chk("s1_ready_mirror",  s1_ready, m_ready);
         chk("m_valid_mirror1",  m_valid,  s1_valid);
      end
      if (dbg_state == IDLE) begin
         chk("idle_ctrl", {m_valid, s0_ready, s1_ready, m_tlast}, 4'b0);
         chk("idle_data", m_data, 256'h0);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n;
      arst = 1'b0;
      m_ready = 1'b1;
      s0_valid = 1'b0; s1_valid = 1'b0;
      s0_data = '0; s0_keep = '0; s0_tlast = 1'b0; s0_tuser = '0;
      s1_data = '0; s1_keep = '0; s1_tlast = 1'b0; s1_tuser = '0;

      // Reset with port 0 requesting; then 3-beat packet on port 0.
      for (int i = 0; i < 3; i++)
         push(1'b0, 256'h22222, 32'h33333, (i == 2), 128'h44444, 1'b1);
      repeat (5) begin
         @(negedge clk);
         chk("rst_m_valid",  m_valid,   1'b0);
         chk("rst_s0_ready", s0_ready,  1'b0);
         chk("rst_s1_ready", s1_ready,  1'b0);
         chk("rst_state",    dbg_state, 2'b00);
         chk("rst_last",     dbg_last,  1'b1);
      end
      arst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("enter_pkt0", dbg_state, 2'b01);
      drain("t2_drain", 20);
      @(negedge clk);
      chk("t2_idle_state", dbg_state, 2'b00);
      chk("t2_last",       dbg_last,  1'b0);
      chk("t2_idle_valid", m_valid,   1'b0);

      // Both request with last=0: port 1 wins; m_ready toggles through its
      // 4-beat packet, then port 0's single-beat packet follows.
      @(posedge clk); #2;
      for (int i = 0; i < 4; i++)
         push(1'b1, 256'h1000 + i, 32'h0000_ff00 + i, (i == 3), 128'h44444, 1'b1);
      push(1'b0, 256'h5000, 32'hffff_ffff, 1'b1, 128'h5555, 1'b1);
      n = 0;
      while (exp_q.size() > 0 && n < 40) begin
         @(posedge clk); #2;
         m_ready = ~m_ready;
         n++;
      end
      chk("t4_drain", exp_q.size(), 0);
      m_ready = 1'b1;
      @(negedge clk);
      chk("t4_state", dbg_state, 2'b00);
      chk("t4_last",  dbg_last,  1'b0);

      // Reset during beat 2 of a port-0 packet.
      @(posedge clk); #2;
      push(1'b0, 256'h7001, 32'h1, 1'b0, 128'h7, 1'b1);
      push(1'b0, 256'h7002, 32'h2, 1'b0, 128'h7, 1'b0);
      push(1'b0, 256'h7003, 32'h3, 1'b1, 128'h7, 1'b0);
      drain("t5_beat1", 20);
      m_ready = 1'b0;
      arst = 1'b0;
      @(negedge clk);
      chk("t5_pre_state", dbg_state, 2'b01);
      @(posedge clk); #2;
      src0_q.delete();
      @(negedge clk);
      chk("t5_state",   dbg_state, 2'b00);
      chk("t5_m_valid", m_valid,   1'b0);
      chk("t5_last",    dbg_last,  1'b1);
      @(posedge clk); #2;
      arst = 1'b1;
      m_ready = 1'b1;

      // Continuous contention after reset: grants go 0,1,0,1.
      @(posedge clk); #2;
      push(1'b0, 256'hA0, 32'hA0, 1'b0, 128'hA, 1'b1);
      push(1'b0, 256'hA1, 32'hA1, 1'b1, 128'hA, 1'b1);
      push(1'b1, 256'hB0, 32'hB0, 1'b0, 128'hB, 1'b1);
      push(1'b1, 256'hB1, 32'hB1, 1'b1, 128'hB, 1'b1);
      push(1'b0, 256'hC0, 32'hC0, 1'b0, 128'hC, 1'b1);
      push(1'b0, 256'hC1, 32'hC1, 1'b1, 128'hC, 1'b1);
      push(1'b1, 256'hD0, 32'hD0, 1'b0, 128'hD, 1'b1);
      push(1'b1, 256'hD1, 32'hD1, 1'b1, 128'hD, 1'b1);
      // Reorder expectation to grant order A,B,C,D.
      exp_q.delete();
      exp_q.push_back('{256'hA0, 32'hA0, 1'b0, 128'hA, 1'b0});
      exp_q.push_back('{256'hA1, 32'hA1, 1'b1, 128'hA, 1'b0});
      exp_q.push_back('{256'hB0, 32'hB0, 1'b0, 128'hB, 1'b1});
      exp_q.push_back('{256'hB1, 32'hB1, 1'b1, 128'hB, 1'b1});
      exp_q.push_back('{256'hC0, 32'hC0, 1'b0, 128'hC, 1'b0});
      exp_q.push_back('{256'hC1, 32'hC1, 1'b1, 128'hC, 1'b0});
      exp_q.push_back('{256'hD0, 32'hD0, 1'b0, 128'hD, 1'b1});
      exp_q.push_back('{256'hD1, 32'hD1, 1'b1, 128'hD, 1'b1});
      drain("t3_drain", 60);
      @(negedge clk);
      chk("t3_state", dbg_state, 2'b00);
      chk("t3_last",  dbg_last,  1'b1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
